fb_stream_writer: RTL and testbench

FB_STREAM_WRITER -- requirements
Module: fb_stream_writer

---
 rtl/paint_pkg.sv | 21 ++
 rtl/rgb444_packer.sv | 56 +++++
 rtl/fb_stream_writer.sv | 122 ++++++++++++
 tb/tb_fb_stream_writer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// -----------------------------------------------------------------------------
// paint_pkg
// Shared definitions for the paint frame-buffer blocks.
//   PIXELS_DEFAULT : pixels per frame (160x120)
//   COLOR_W        : frame-buffer colour width, {R[3:0],G[3:0],B[3:0]}
//   fb_state_t     : state encoding of the stream-writer FSM
// -----------------------------------------------------------------------------
package paint_pkg;

    localparam int PIXELS_DEFAULT = 19200;
    localparam int COLOR_W        = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HI    = 3'd1,
        ST_LO    = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } fb_state_t;

endpackage

// File: rtl/rgb444_packer.sv
// -----------------------------------------------------------------------------
// rgb444_packer
// Assembles one RGB444 pixel from two incoming bytes.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : discard any partial pixel (registers back to 0)
//   hi_stb      : byte_in carries {R,G}
//   lo_stb      : byte_in carries {B,unused}
//   consume     : the assembled pixel has been written out
//   byte_in     : incoming byte
//   color       : registered {R,G,B}
//   pixel_valid : a complete pixel is held and not yet consumed
// -----------------------------------------------------------------------------
module rgb444_packer
    import paint_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               hi_stb,
    input  logic               lo_stb,
    input  logic               consume,
    input  logic [7:0]         byte_in,
    output logic [COLOR_W-1:0] color,
    output logic               pixel_valid
);

    logic [3:0] r_q;
    logic [3:0] g_q;
    logic [3:0] b_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_q         <= 4'd0;
            g_q         <= 4'd0;
            b_q         <= 4'd0;
            pixel_valid <= 1'b0;
        end else begin
            if (hi_stb) begin
                r_q         <= byte_in[7:4];
                g_q         <= byte_in[3:0];
                pixel_valid <= 1'b0;
            end
            if (lo_stb) begin
                // Low nibble of the second byte carries no colour information.
                b_q         <= byte_in[7:4];
                pixel_valid <= 1'b1;
            end
            if (consume) begin
                pixel_valid <= 1'b0;
            end
        end
    end

    assign color = {r_q, g_q, b_q};

endmodule

// File: rtl/fb_stream_writer.sv
// -----------------------------------------------------------------------------
// fb_stream_writer
// Loads one frame of RGB444 pixels, two bytes per pixel, from a byte stream
// into the frame buffer, holding off while the display owns the buffer.
//   clk, reset  : clock, synchronous active-high reset
//   start       : begin loading a frame (honoured only when idle)
//   abort       : cancel a load; wins over start, byte transfers and writes
//   byte_in     : incoming byte
//   byte_valid  : byte_in is valid
//   byte_ready  : block accepts byte_in this cycle
//   screen_on   : display owns the frame buffer, writes are held off
//   fb_a/fb_we/fb_wd : frame-buffer write port
//   busy        : load in progress
//   done        : one-cycle pulse after the last pixel is written
//   state_dbg   : current FSM state
//
// Byte handshake: a byte moves only in a cycle where byte_valid and
// byte_ready are both 1; the source must hold byte_in/byte_valid stable
// until then. byte_ready depends on state only, never on byte_valid.
// -----------------------------------------------------------------------------
module fb_stream_writer
    import paint_pkg::*;
#(
    parameter int PIXELS = PIXELS_DEFAULT,
    parameter int AW     = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               screen_on,
    output logic [AW-1:0]      fb_a,
    output logic               fb_we,
    output logic [COLOR_W-1:0] fb_wd,
    output logic               busy,
    output logic               done,
    output fb_state_t          state_dbg
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

    fb_state_t     state_q;
    fb_state_t     state_d;
    logic [AW-1:0] addr_q;
    logic          xfer;
    logic          hi_stb;
    logic          lo_stb;
    logic          last_pixel;
    logic          pixel_valid;

    assign byte_ready = (state_q == ST_HI) || (state_q == ST_LO);

    // Abort and reset discard whatever is on the byte bus this cycle.
    assign xfer   = byte_valid && byte_ready && !abort && !reset;
    assign hi_stb = xfer && (state_q == ST_HI);
    assign lo_stb = xfer && (state_q == ST_LO);

    // pixel_valid is always set in WRITE; it only guards against writing a
    // pixel that was never assembled.
    assign fb_we = (state_q == ST_WRITE) && !screen_on && pixel_valid
                   && !abort && !reset;

    assign last_pixel = (addr_q == LAST_ADDR);

    rgb444_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear       (abort),
        .hi_stb      (hi_stb),
        .lo_stb      (lo_stb),
        .consume     (fb_we),
        .byte_in     (byte_in),
        .color       (fb_wd),
        .pixel_valid (pixel_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start)  state_d = ST_HI;
                ST_HI:    if (hi_stb) state_d = ST_LO;
                ST_LO:    if (lo_stb) state_d = ST_WRITE;
                ST_WRITE: if (fb_we)  state_d = last_pixel ? ST_DONE : ST_HI;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Address stops at the last pixel; it never wraps back to 0 on its own.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else if (!abort) begin
            if ((state_q == ST_IDLE) && start) begin
                addr_q <= '0;
            end else if (fb_we && !last_pixel) begin
                addr_q <= addr_q + AW'(1);
            end
        end
    end

    assign fb_a      = addr_q;
    assign busy      = (state_q == ST_HI) || (state_q == ST_LO) || (state_q == ST_WRITE);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fb_stream_writer.sv
// -----------------------------------------------------------------------------
// tb_fb_stream_writer
// Self-checking bench for fb_stream_writer: reset checks, a vector table of
// pixels, hand-written corner sequences, and one full random frame. Every
// frame-buffer write is compared against an expected {address, colour} queue.
// -----------------------------------------------------------------------------
module tb_fb_stream_writer;
    import paint_pkg::*;

    localparam int PIXELS = 19200;
    localparam int AW     = 15;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            abort;
    logic [7:0]      byte_in;
    logic            byte_valid;
    logic            byte_ready;
    logic            screen_on;
    logic [AW-1:0]   fb_a;
    logic            fb_we;
    logic [11:0]     fb_wd;
    logic            busy;
    logic            done;
    fb_state_t       state_dbg;

    always #5 clk = ~clk;

    fb_stream_writer #(.PIXELS(PIXELS), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .screen_on  (screen_on),
        .fb_a       (fb_a),
        .fb_we      (fb_we),
        .fb_wd      (fb_wd),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks      = 0;
    int failures    = 0;
    int write_count = 0;
    int done_count  = 0;
    logic [AW+11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        logic [AW+11:0] e;
        if (done) done_count++;
        if (fb_we) begin
            write_count++;
            if (exp_q.size() == 0) begin
                check("write_when_none_expected", 32'(fb_we), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(fb_a), 32'(e[AW+11:12]));
                check("wr_data", 32'(fb_wd), 32'(e[11:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one byte and returns #1 after the edge on which it transferred.
    task automatic send_byte(input logic [7:0] b, output logic ok);
        ok = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        byte_valid = 1'b0;
        if (!ok) check("byte_accept_timeout", 32'(byte_ready), 32'd1);
    endtask

    task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo,
                              input int addr, input logic [11:0] wd, output logic ok);
        logic ok_hi;
        send_byte(hi, ok_hi);
        if (ok_hi && ($urandom_range(0, 7) == 0)) begin
            @(posedge clk); #1;
        end
        if (ok_hi) begin
            send_byte(lo, ok);
            if (ok) exp_q.push_back({AW'(addr), wd});
        end else begin
            ok = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [11:0] wd;
    } vec_t;

    vec_t        tv[6];
    logic        ok;
    logic        frame_ok;
    logic [7:0]  rh;
    logic [7:0]  rl;
    int          wc0;
    int          we_seen;
    int          rdy_seen;

    initial begin
        tv[0] = '{8'h12, 8'h30, 12'h123};
        tv[1] = '{8'hFF, 8'hF0, 12'hFFF};
        tv[2] = '{8'h00, 8'h0F, 12'h000};
        tv[3] = '{8'h5A, 8'hA5, 12'h5AA};
        tv[4] = '{8'h9C, 8'h7E, 12'h9C7};
        tv[5] = '{8'h01, 8'hFF, 12'h01F};

        reset = 1'b1; start = 1'b0; abort = 1'b0;
        byte_in = 8'h00; byte_valid = 1'b0; screen_on = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fb_a", 32'(fb_a), 32'd0);
        check("rst_fb_wd", 32'(fb_wd), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));

        // First pixel 0xAB,0xC0 -> address 0, colour 0xABC
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(byte_ready), 32'd1);
        send_pixel(8'hAB, 8'hC0, 0, 12'hABC, ok);
        @(posedge clk); #1;
        check("first_state_hi", 32'(state_dbg), 32'(ST_HI));
        check("first_busy", 32'(busy), 32'd1);
        check("first_fb_a", 32'(fb_a), 32'd1);
        check("first_write_count", 32'(write_count), 32'd1);

        // Vector table, addresses 1..6
        for (int i = 0; i < 6; i++) begin
            send_pixel(tv[i].hi, tv[i].lo, 1 + i, tv[i].wd, ok);
        end
        @(posedge clk); #1;
        check("table_fb_a", 32'(fb_a), 32'd7);
        check("table_write_count", 32'(write_count), 32'd7);
        check("table_queue_empty", 32'(exp_q.size()), 32'd0);

        // Display owns the buffer for 50 cycles while a pixel waits in WRITE
        send_byte(8'h3C, ok);
        screen_on = 1'b1;
        send_byte(8'hD2, ok);
        exp_q.push_back({AW'(7), 12'h3CD});
        wc0 = write_count; we_seen = 0; rdy_seen = 0;
        repeat (50) begin
            @(negedge clk);
            we_seen  += int'(fb_we);
            rdy_seen += int'(byte_ready);
        end
        check("screen_hold_we", 32'(we_seen), 32'd0);
        check("screen_hold_ready", 32'(rdy_seen), 32'd0);
        check("screen_hold_state", 32'(state_dbg), 32'(ST_WRITE));
        check("screen_hold_fb_a", 32'(fb_a), 32'd7);
        @(posedge clk); #1;
        screen_on = 1'b0;
        @(posedge clk); #1;
        check("screen_release_writes", 32'(write_count - wc0), 32'd1);
        check("screen_release_fb_a", 32'(fb_a), 32'd8);
        check("screen_release_state", 32'(state_dbg), 32'(ST_HI));

        // start mid-frame is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("midstart_state", 32'(state_dbg), 32'(ST_HI));
        check("midstart_fb_a", 32'(fb_a), 32'd8);

        // Reset while a pixel is ready to write: no write, outputs cleared
        send_byte(8'h11, ok);
        check("midreset_state_lo", 32'(state_dbg), 32'(ST_LO));
        send_byte(8'h22, ok);
        reset = 1'b1;
        @(negedge clk);
        check("reset_cycle_we", 32'(fb_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("postreset_outputs",
              {20'd0, 32'(fb_a) == 0, fb_wd == 12'd0, fb_we, byte_ready, busy, done},
              {20'd0, 1'b1, 1'b1, 4'b0000});
        check("postreset_state", 32'(state_dbg), 32'(ST_IDLE));

        // Abort in LO with a byte offered: byte dropped, back to IDLE
        pulse_start();
        send_byte(8'h77, ok);
        byte_in = 8'h88; byte_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; byte_valid = 1'b0;
        check("abort_lo_state", 32'(state_dbg), 32'(ST_IDLE));
        check("abort_lo_busy", 32'(busy), 32'd0);
        check("abort_lo_ready", 32'(byte_ready), 32'd0);

        // Abort in WRITE suppresses the write
        pulse_start();
        send_byte(8'h99, ok);
        wc0 = write_count;
        send_byte(8'hAA, ok);
        abort = 1'b1;
        @(negedge clk);
        check("abort_write_we", 32'(fb_we), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_write_state", 32'(state_dbg), 32'(ST_IDLE));
        check("abort_write_count", 32'(write_count - wc0), 32'd0);

        // New start reloads from address 0
        pulse_start();
        send_pixel(8'h4B, 8'h6F, 0, 12'h4B6, ok);
        @(posedge clk); #1;
        check("reload_fb_a", 32'(fb_a), 32'd1);
        check("reload_queue_empty", 32'(exp_q.size()), 32'd0);

        // Full random frame
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        done_count = 0;
        wc0 = write_count;
        frame_ok = 1'b1;
        pulse_start();
        for (int p = 0; p < PIXELS && frame_ok; p++) begin
            rh = 8'($urandom_range(0, 255));
            rl = 8'($urandom_range(0, 255));
            send_pixel(rh, rl, p, {rh, rl[7:4]}, ok);
            frame_ok = ok;
        end
        repeat (4) @(negedge clk);
        check("frame_complete", 32'(frame_ok), 32'd1);
        check("frame_writes", 32'(write_count - wc0), 32'(PIXELS));
        check("frame_done_pulses", 32'(done_count), 32'd1);
        check("frame_busy", 32'(busy), 32'd0);
        check("frame_state", 32'(state_dbg), 32'(ST_IDLE));
        check("frame_fb_a_no_wrap", 32'(fb_a), 32'(PIXELS - 1));
        check("frame_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
